// File: rtl/param_data_mem_pkg.sv
// Shared types and helpers for the parametrised data/instruction memory.
package mem_pkg;

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam int READ_LAT_MAX = 4;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/param_data_mem_if.sv
// Request/response bus between the load/store/fetch unit and the memory.
interface param_data_mem_if import mem_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  localparam int BE_W = be_width(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_we;
  logic              init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_we, init_done
  );
endinterface

// File: rtl/param_data_mem_rsp_pipe.sv
// Fixed-latency response delay line; stage 0 is the combinational input,
// stage STAGES drives the outputs.
module mem_rsp_pipe import mem_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_we,
  input  logic              in_err,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic              out_we,
  output logic              out_err,
  output logic [DATA_W-1:0] out_data
);
  typedef struct packed {
    logic              we;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic vld_pipe [STAGES:0];
  rsp_t dat_pipe [STAGES:0];

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = '{we: in_we, err: in_err, data: in_data};

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_pipe[g] <= 1'b0;
        dat_pipe[g] <= '0;
      end else begin
        vld_pipe[g] <= vld_pipe[g-1];
        dat_pipe[g] <= dat_pipe[g-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_we    = dat_pipe[STAGES].we;
  assign out_err   = dat_pipe[STAGES].err;
  assign out_data  = dat_pipe[STAGES].data;
endmodule

// File: rtl/param_data_mem.sv
// Single-port memory with byte enables, fixed read latency, range check
// and a post-reset clear sweep that gates req_ready.
module param_data_mem import mem_pkg::*; #(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 12,
  parameter int              DEPTH      = 4096,
  parameter int              READ_LAT   = 1,
  parameter int              INIT_CLEAR = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  param_data_mem_if.slave bus
);
  localparam int BE_W  = be_width(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state, state_nx;
  logic [IDX_W-1:0]  cnt, cnt_nx;
  logic              sweep_we, ready;
  logic              acc, in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;

  assign acc      = bus.req_valid && ready;
  assign in_range = {1'b0, bus.req_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = bus.req_addr[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sweep_we = 1'b0;
    ready    = 1'b0;
    case (state)
      S_INIT: begin
        if (INIT_CLEAR != 0) begin
          sweep_we = 1'b1;
          if (cnt == IDX_W'(DEPTH-1)) state_nx = S_RUN;
          else                        cnt_nx   = cnt + 1'b1;
        end else begin
          state_nx = S_RUN;
        end
      end
      S_RUN:   ready = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

  // Sweep and bus writes never overlap: bus accepts only once ready.
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[cnt] <= INIT_VAL;
    end else if (acc && bus.req_we && in_range) begin
      for (int i = 0; i < BE_W; i++)
        if (bus.req_be[i]) mem[idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
    end
  end

  // Only in-range reads carry data, so idle/write/error slots stay zero.
  assign rd_data = (acc && !bus.req_we && in_range) ? mem[idx] : '0;

  mem_rsp_pipe #(.DATA_W(DATA_W), .STAGES(READ_LAT)) u_rsp_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (acc),
    .in_we     (acc && bus.req_we),
    .in_err    (acc && !in_range),
    .in_data   (rd_data),
    .out_valid (bus.rsp_valid),
    .out_we    (bus.rsp_we),
    .out_err   (bus.rsp_err),
    .out_data  (bus.rsp_rdata)
  );

  assign bus.req_ready = ready;
  assign bus.init_done = ready;
endmodule

// File: tb/tb_param_data_mem.sv
// Directed bench: DEPTH=64, READ_LAT=3, sweep value A5A5; responses are
// logged with their cycle number and matched against hand-written expectations.
module tb_param_data_mem;
  localparam int L     = 3;
  localparam int DEPTH = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_data_mem_if #(.DATA_W(16), .ADDR_W(12)) bus();

  param_data_mem #(
    .DATA_W(16), .ADDR_W(12), .DEPTH(DEPTH), .READ_LAT(L),
    .INIT_CLEAR(1), .INIT_VAL(16'hA5A5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic        err;
    logic [15:0] data;
    string       tag;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t act_q[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   idle_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rsp_t a;
    if (bus.rsp_valid) begin
      a.cyc = cyc; a.we = bus.rsp_we; a.err = bus.rsp_err;
      a.data = bus.rsp_rdata; a.tag = "";
      act_q.push_back(a);
    end else if (bus.rsp_rdata != 16'h0 || bus.rsp_err || bus.rsp_we) begin
      idle_bad++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
  endtask

  task automatic req(input logic we, input logic [11:0] a, input logic [15:0] d,
                     input logic [1:0] be, input logic err, input logic [15:0] exp_d,
                     input string tag);
    rsp_t e;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a;
    bus.req_wdata = d;    bus.req_be = be;
    e.cyc = cyc + L; e.we = we; e.err = err; e.data = exp_d; e.tag = tag;
    exp_q.push_back(e);
    tick;
  endtask

  task automatic drain;
    rsp_t e, a;
    idle;
    repeat (L + 2) tick;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_q.size() == 0) begin
        chk({e.tag, " missing"}, 32'd0, 32'd1);
      end else begin
        a = act_q.pop_front();
        chk({e.tag, " cyc"},  a.cyc,  e.cyc);
        chk({e.tag, " we"},   a.we,   e.we);
        chk({e.tag, " err"},  a.err,  e.err);
        chk({e.tag, " data"}, a.data, e.data);
      end
    end
    chk("extra rsp", act_q.size(), 0);
  endtask

  // Release reset mid-cycle and time the sweep; ready must not lead init_done.
  task automatic release_wait(input string tag);
    int r;
    bit early;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;
    early = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cyc - r == 10) idle;
      if (bus.init_done) break;
      if (bus.req_ready) early = 1'b1;
    end
    chk({tag, " init cycles"}, cyc - r, 64);
    chk({tag, " ready"}, bus.req_ready, 1'b1);
    chk({tag, " ready early"}, early, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_be = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", bus.req_ready, 1'b0);
    chk("rst init_done", bus.init_done, 1'b0);
    chk("rst rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst rsp_rdata", bus.rsp_rdata, 16'h0);
    chk("rst rsp_err",   bus.rsp_err,   1'b0);
    chk("rst rsp_we",    bus.rsp_we,    1'b0);

    release_wait("sweep");
    tick;
    req(0, 12'd0,  16'h0, 2'b00, 0, 16'hA5A5, "rd w0");
    req(0, 12'd31, 16'h0, 2'b00, 0, 16'hA5A5, "rd w31");
    req(0, 12'd63, 16'h0, 2'b00, 0, 16'hA5A5, "rd w63");
    drain;

    req(1, 12'h010, 16'h1234, 2'b11, 0, 16'h0,    "wr be11");
    req(1, 12'h010, 16'hFF00, 2'b10, 0, 16'h0,    "wr be10");
    req(0, 12'h010, 16'h0,    2'b00, 0, 16'hFF34, "rd be");
    req(1, 12'h010, 16'hFFFF, 2'b00, 0, 16'h0,    "wr be00");
    req(0, 12'h010, 16'h0,    2'b00, 0, 16'hFF34, "rd be00");
    drain;

    for (int i = 0; i < 8; i++)
      req(1, 12'(i), 16'hC000 | 16'(i), 2'b11, 0, 16'h0, $sformatf("wr s%0d", i));
    for (int i = 0; i < 8; i++)
      req(0, 12'(i), 16'h0, 2'b00, 0, 16'hC000 | 16'(i), $sformatf("rd s%0d", i));
    drain;

    req(1, 12'd5, 16'h0BEE, 2'b11, 0, 16'h0,    "raw wr");
    req(0, 12'd5, 16'h0,    2'b00, 0, 16'h0BEE, "raw rd");
    drain;

    req(1, 12'd100,  16'hDEAD, 2'b11, 1, 16'h0,    "oor wr");
    req(0, 12'd100,  16'h0,    2'b00, 1, 16'h0,    "oor rd");
    req(0, 12'd36,   16'h0,    2'b00, 0, 16'hA5A5, "alias 36");
    req(0, 12'd64,   16'h0,    2'b00, 1, 16'h0,    "oor 64");
    req(1, 12'hFFF,  16'h1111, 2'b11, 1, 16'h0,    "oor fff wr");
    req(0, 12'd63,   16'h0,    2'b00, 0, 16'hA5A5, "edge 63");
    drain;

    // Two reads in flight when reset hits; their responses must vanish.
    req(0, 12'd5, 16'h0, 2'b00, 0, 16'h0BEE, "fl0");
    req(0, 12'd6, 16'h0, 2'b00, 0, 16'hC006, "fl1");
    exp_q.delete();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'd7;
    rst_n = 1'b0;
    repeat (3) tick;
    chk("mid rst ready", bus.req_ready, 1'b0);
    release_wait("resweep");
    repeat (6) tick;
    chk("no rsp after rst", act_q.size(), 0);
    req(0, 12'd5,  16'h0, 2'b00, 0, 16'hA5A5, "resweep w5");
    req(0, 12'd0,  16'h0, 2'b00, 0, 16'hA5A5, "resweep w0");
    req(0, 12'd16, 16'h0, 2'b00, 0, 16'hA5A5, "resweep w16");
    drain;

    chk("idle outputs zero", idle_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
